// File: rtl/note_lane_scroller_pkg.sv
// Shared definitions for the note lane scroller and its consumers.
// The pixel renderer uses the same coordinate widths, so both sides agree on
// how note positions are packed.
package note_lane_scroller_pkg;

  // Coordinate widths shared with the renderer
  localparam int unsigned NOTE_Y_W = 12;
  localparam int unsigned NOTE_X_W = 10;

  // Screen geometry
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned SCREEN_W_DEF = 640;

  // Default strike zone for a lane (inclusive bounds on note top-left y)
  localparam int unsigned HIT_Y_MIN_DEF = 400;
  localparam int unsigned HIT_Y_MAX_DEF = 440;

  localparam int unsigned SPEED_W = 4;
  localparam int unsigned COMBO_W = 16;

  typedef logic [NOTE_Y_W-1:0] note_y_t;
  typedef logic [COMBO_W-1:0]  combo_t;

  // Outcome of judging a strum in one cycle
  typedef enum logic [1:0] {
    JudgeNone,
    JudgeHit,
    JudgeBad
  } judge_e;

  // Combo counter increment that sticks at all-ones
  function automatic combo_t combo_sat_inc(input combo_t c);
    return (&c) ? c : c + combo_t'(1);
  endfunction

endpackage

// File: rtl/note_lane_scroller_if.sv
// Lane handshake and judgement bundle.
//   spawn_valid / spawn_ready : note creation handshake
//   strum                     : one-cycle player strum pulse
//   hit / miss / bad_strum    : one-cycle judgement pulses
//   combo                     : consecutive-hit counter
// master = game sequencer / player input side, slave = the scroller.
interface note_lane_scroller_if;
  import note_lane_scroller_pkg::*;

  logic   spawn_valid;
  logic   spawn_ready;
  logic   strum;
  logic   hit;
  logic   miss;
  logic   bad_strum;
  combo_t combo;

  modport master (
    output spawn_valid,
    output strum,
    input  spawn_ready,
    input  hit,
    input  miss,
    input  bad_strum,
    input  combo
  );

  modport slave (
    input  spawn_valid,
    input  strum,
    output spawn_ready,
    output hit,
    output miss,
    output bad_strum,
    output combo
  );

endinterface

// File: rtl/note_lane_scroller_strike_select.sv
// Combinational strike-zone selector.
// Picks the active slot inside [HIT_Y_MIN, HIT_Y_MAX] with the largest y
// (closest to the player); ties go to the lowest index.
//   y_flat : packed slot y values, slot i at [NOTE_Y_W*i +: NOTE_Y_W]
//   active : slot valid mask
//   found  : at least one slot is in the zone
//   sel    : one-hot selected slot (all zero when found is low)
module note_strike_select
  import note_lane_scroller_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned HIT_Y_MIN = HIT_Y_MIN_DEF,
  parameter int unsigned HIT_Y_MAX = HIT_Y_MAX_DEF
) (
  input  logic [NOTE_Y_W*NUM_SLOTS-1:0] y_flat,
  input  logic [NUM_SLOTS-1:0]          active,
  output logic                          found,
  output logic [NUM_SLOTS-1:0]          sel
);

  note_y_t best_y;
  note_y_t y_cur;

  always_comb begin
    found  = 1'b0;
    sel    = '0;
    best_y = '0;
    y_cur  = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      y_cur = y_flat[NOTE_Y_W*i +: NOTE_Y_W];
      // Strict '>' keeps the earlier (lower-index) slot on a tie
      if (active[i] && (y_cur >= note_y_t'(HIT_Y_MIN)) && (y_cur <= note_y_t'(HIT_Y_MAX)) &&
          (!found || (y_cur > best_y))) begin
        found  = 1'b1;
        sel    = '0;
        sel[i] = 1'b1;
        best_y = y_cur;
      end
    end
  end

endmodule

// File: rtl/note_lane_scroller.sv
// Falling-note position owner for one guitar lane.
// Spawns notes into a fixed slot pool, advances them once per frame, retires
// notes that leave the screen and judges strums against the strike zone.
// The renderer reads note_y_flat/active for its note-bounds hit test.
//   clock, reset : clock and synchronous active-high reset
//   frame_tick   : one-cycle pulse per frame
//   speed        : pixels added to every active note per frame
//   lane         : spawn handshake, strum input, judgement outputs, combo
//   note_y_flat  : slot i y at [NOTE_Y_W*i +: NOTE_Y_W]
//   active       : slot valid mask (inactive slots hold a stale y)
module note_lane_scroller
  import note_lane_scroller_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SPAWN_Y   = 0,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
  parameter int unsigned HIT_Y_MIN = HIT_Y_MIN_DEF,
  parameter int unsigned HIT_Y_MAX = HIT_Y_MAX_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [SPEED_W-1:0]            speed,
  note_lane_scroller_if.slave           lane,
  output logic [NOTE_Y_W*NUM_SLOTS-1:0] note_y_flat,
  output logic [NUM_SLOTS-1:0]          active
);

  note_y_t              y_q [NUM_SLOTS];
  note_y_t              y_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic                 hit_q, miss_q, bad_q;
  logic                 miss_d;
  combo_t               combo_q, combo_d;
  judge_e               judge;

  logic                 spawn_ready;
  logic                 free_found;
  logic                 strike_found;
  logic [NUM_SLOTS-1:0] strike_sel;

  // Pack registered positions for the renderer and the selector
  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_pack
    assign note_y_flat[NOTE_Y_W*g +: NOTE_Y_W] = y_q[g];
  end

  assign spawn_ready    = ~&active_q;
  assign active         = active_q;
  assign lane.spawn_ready = spawn_ready;
  assign lane.hit       = hit_q;
  assign lane.miss      = miss_q;
  assign lane.bad_strum = bad_q;
  assign lane.combo     = combo_q;

  note_strike_select #(
    .NUM_SLOTS (NUM_SLOTS),
    .HIT_Y_MIN (HIT_Y_MIN),
    .HIT_Y_MAX (HIT_Y_MAX)
  ) u_strike_select (
    .y_flat (note_y_flat),
    .active (active_q),
    .found  (strike_found),
    .sel    (strike_sel)
  );

  // Strum, then frame advance, then spawn -- all judged on pre-cycle state.
  always_comb begin
    active_d   = active_q;
    y_d        = y_q;
    judge      = JudgeNone;
    miss_d     = 1'b0;
    free_found = 1'b0;

    if (lane.strum) begin
      if (strike_found) begin
        active_d = active_q & ~strike_sel;
        judge    = JudgeHit;
      end else begin
        judge = JudgeBad;
      end
    end

    // A slot just struck is already cleared in active_d, so it is not moved
    if (frame_tick) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (active_d[i]) begin
          y_d[i] = y_q[i] + note_y_t'(speed);
          if (y_d[i] >= note_y_t'(SCREEN_H)) begin
            active_d[i] = 1'b0;
            miss_d      = 1'b1;
          end
        end
      end
    end

    // Target comes from the registered mask, so slots freed this cycle wait
    if (lane.spawn_valid && spawn_ready) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (!active_q[i] && !free_found) begin
          free_found  = 1'b1;
          active_d[i] = 1'b1;
          y_d[i]      = note_y_t'(SPAWN_Y);
        end
      end
    end

    // Miss dominates a simultaneous hit
    if (miss_d || (judge == JudgeBad)) begin
      combo_d = '0;
    end else if (judge == JudgeHit) begin
      combo_d = combo_sat_inc(combo_q);
    end else begin
      combo_d = combo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      bad_q    <= 1'b0;
      combo_q  <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        y_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      hit_q    <= (judge == JudgeHit);
      miss_q   <= miss_d;
      bad_q    <= (judge == JudgeBad);
      combo_q  <= combo_d;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        y_q[i] <= y_d[i];
      end
    end
  end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller with hand-computed expectations.
module tb_note_lane_scroller;
  import note_lane_scroller_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  speed;
  logic [47:0] note_y_flat;
  logic [3:0]  active;

  int n_cmp = 0;
  int n_bad = 0;

  note_lane_scroller_if lane();

  note_lane_scroller #(
    .NUM_SLOTS (4),
    .SPAWN_Y   (0),
    .SCREEN_H  (480),
    .HIT_Y_MIN (400),
    .HIT_Y_MAX (440)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .speed       (speed),
    .lane        (lane),
    .note_y_flat (note_y_flat),
    .active      (active)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] y_of(input int i);
    return note_y_flat[12*i +: 12];
  endfunction

  // Drive one cycle of inputs, sample 1 ns after the edge
  task automatic cycle(input logic fr, input logic st, input logic sv);
    frame_tick       = fr;
    lane.strum       = st;
    lane.spawn_valid = sv;
    @(posedge clock);
    #1;
    frame_tick       = 1'b0;
    lane.strum       = 1'b0;
    lane.spawn_valid = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    frame_tick       = 1'b0;
    speed            = 4'd0;
    lane.strum       = 1'b0;
    lane.spawn_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Reset state
    check("rst_active", active, 0);
    check("rst_y", note_y_flat, 0);
    check("rst_combo", lane.combo, 0);
    check("rst_pulses", {lane.hit, lane.miss, lane.bad_strum}, 0);
    check("rst_ready", lane.spawn_ready, 1);

    // Fill all slots; fifth request is ignored
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      check("fill_active", active, (k >= 4) ? 4'hF : (4'h1 << k) - 4'h1);
      check("fill_ready", lane.spawn_ready, (k < 4) ? 1 : 0);
    end
    check("fill_y", note_y_flat, 0);

    // Three hits at the zone's lower bound, building combo to 3
    do_reset();
    speed = 4'd8;
    for (int h = 1; h <= 3; h++) begin
      cycle(1'b0, 1'b0, 1'b1);
      frames(50);
      check("adv_y400", y_of(0), 400);
      check("adv_active", active, 4'b0001);
      cycle(1'b0, 1'b1, 1'b0);
      check("hit_pulse", lane.hit, 1);
      check("hit_active", active, 0);
      check("hit_combo", lane.combo, h);
      if (h == 1) begin
        cycle(1'b0, 1'b0, 1'b0);
        check("hit_one_cycle", lane.hit, 0);
      end
    end

    // Retire off-screen: 60th tick reaches 480
    cycle(1'b0, 1'b0, 1'b1);
    frames(59);
    check("pre_miss_y", y_of(0), 472);
    check("pre_miss_active", active, 4'b0001);
    check("pre_miss_combo", lane.combo, 3);
    frames(1);
    check("miss_y", y_of(0), 480);
    check("miss_active", active, 0);
    check("miss_pulse", lane.miss, 1);
    check("miss_combo", lane.combo, 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("miss_one_cycle", lane.miss, 0);

    // Slots 0/1/2 at 460/430/410: largest in-zone y wins
    do_reset();
    speed = 4'd10;
    cycle(1'b0, 1'b0, 1'b1);
    frames(2);
    cycle(1'b1, 1'b0, 1'b1);
    frames(1);
    cycle(1'b1, 1'b0, 1'b1);
    frames(41);
    check("sel_y0", y_of(0), 460);
    check("sel_y1", y_of(1), 430);
    check("sel_y2", y_of(2), 410);
    cycle(1'b0, 1'b1, 1'b0);
    check("sel_active", active, 4'b0101);
    check("sel_hit", lane.hit, 1);
    check("sel_combo", lane.combo, 1);
    cycle(1'b0, 1'b1, 1'b0);
    check("sel2_active", active, 4'b0001);
    check("sel2_combo", lane.combo, 2);
    // Only y=460 left, above the zone
    cycle(1'b0, 1'b1, 1'b0);
    check("above_bad", lane.bad_strum, 1);
    check("above_hit", lane.hit, 0);
    check("above_combo", lane.combo, 0);
    check("above_active", active, 4'b0001);

    // Only y=300 present, below the zone
    do_reset();
    cycle(1'b0, 1'b0, 1'b1);
    frames(30);
    check("below_y", y_of(0), 300);
    cycle(1'b0, 1'b1, 1'b0);
    check("below_bad", lane.bad_strum, 1);
    check("below_active", active, 4'b0001);

    // Strum + frame + spawn together
    do_reset();
    speed = 4'd4;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    frames(108);
    check("same_pre_y0", y_of(0), 440);
    check("same_pre_y2", y_of(2), 432);
    speed = 4'd0;
    frames(1);
    check("pause_y0", y_of(0), 440);
    speed = 4'd4;
    cycle(1'b1, 1'b1, 1'b1);
    check("same_active", active, 4'b1110);
    check("same_y0", y_of(0), 440);
    check("same_y1", y_of(1), 440);
    check("same_y2", y_of(2), 436);
    check("same_y3", y_of(3), 0);
    check("same_hit", lane.hit, 1);
    check("same_combo", lane.combo, 1);
    check("same_miss", lane.miss, 0);

    // Reset mid-frame with three live notes
    speed = 4'd15;
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    check("mid_rst_active", active, 0);
    check("mid_rst_combo", lane.combo, 0);
    check("mid_rst_miss", lane.miss, 0);
    check("mid_rst_y", note_y_flat, 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("mid_rst_miss2", lane.miss, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
